// File: rtl/instruction_fetch.sv
// KGPRisc instruction fetch stage: owns the PC, reads instruction memory and
// registers the returned word into the IF/ID stage with stall, redirect and halt handling.
module instruction_fetch #(
    parameter int         size     = 32,
    parameter int         MemSize  = 32,
    parameter int         RESET_PC = 0,
    parameter logic [5:0] HALT_OP  = 6'b111111
) (
    input  logic            clka,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect,
    input  logic [size-1:0] redirect_addr,
    output logic [size-1:0] imem_addr,
    output logic            imem_we,
    input  logic [size-1:0] imem_data,
    output logic [size-1:0] if_instr,
    output logic [size-1:0] if_pc,
    output logic            if_valid,
    output logic            halted,
    output logic            fault
);

    localparam logic [size-1:0] LAST_PC  = size'(MemSize - 1);
    localparam logic [size-1:0] RST_PC   = size'(RESET_PC);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t          state;
    logic [size-1:0] pc_p0;
    logic [size-1:0] instr_p1;
    logic [size-1:0] pc_p1;
    logic            vld_p1;
    logic            fault_q;

    // Sequential successor, wrapping at the top of instruction memory.
    function automatic logic [size-1:0] next_pc(input logic [size-1:0] pc);
        if (pc == LAST_PC)
            return '0;
        else
            return pc + 1'b1;
    endfunction

    function automatic logic addr_legal(input logic [size-1:0] addr);
        return addr <= LAST_PC;
    endfunction

    function automatic logic is_halt(input logic [size-1:0] instr);
        return instr[size-1 -: 6] == HALT_OP;
    endfunction

    assign imem_addr = pc_p0;
    assign imem_we   = 1'b0;
    assign if_instr  = instr_p1;
    assign if_pc     = pc_p1;
    assign if_valid  = vld_p1;
    assign fault     = fault_q;
    assign halted    = (state == S_HALT);

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_START;
            pc_p0    <= RST_PC;
            instr_p1 <= '0;
            pc_p1    <= '0;
            vld_p1   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state)
                S_START: begin
                    state <= S_RUN;
                end

                // p0 -> p1: capture imem_data for the PC currently on imem_addr
                S_RUN: begin
                    if (redirect && !addr_legal(redirect_addr)) begin
                        fault_q <= 1'b1;
                        vld_p1  <= 1'b0;
                        state   <= S_HALT;
                    end else if (redirect) begin
                        pc_p0  <= redirect_addr;
                        vld_p1 <= 1'b0;
                    end else if (!stall) begin
                        instr_p1 <= imem_data;
                        pc_p1    <= pc_p0;
                        vld_p1   <= 1'b1;
                        if (is_halt(imem_data))
                            state <= S_HALT;
                        else
                            pc_p0 <= next_pc(pc_p0);
                    end
                end

                // A fault makes the halt permanent until reset.
                S_HALT: begin
                    if (redirect && !addr_legal(redirect_addr)) begin
                        fault_q <= 1'b1;
                        vld_p1  <= 1'b0;
                    end else if (redirect && !fault_q) begin
                        pc_p0  <= redirect_addr;
                        vld_p1 <= 1'b0;
                        state  <= S_RUN;
                    end else if (!stall) begin
                        vld_p1 <= 1'b0;
                    end
                end

                default: begin
                    state <= S_START;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized
// stall/redirect/halt traffic compared against a cycle-level behavioural model.
module tb_instruction_fetch;

    localparam int MEMSZ = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic [31:0] imem_addr;
    logic        imem_we;
    logic [31:0] imem_data;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        halted;
    logic        fault;

    logic [31:0] mem [0:MEMSZ-1];

    int n_cmp = 0;
    int n_fail = 0;

    // Behavioural model: mode 0 = just out of reset, 1 = fetching, 2 = stopped
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_ipc;
    logic        m_vld, m_fault;

    instruction_fetch #(.size(32), .MemSize(MEMSZ), .RESET_PC(0), .HALT_OP(6'b111111)) dut (
        .clka(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_addr(redirect_addr), .imem_addr(imem_addr), .imem_we(imem_we),
        .imem_data(imem_data), .if_instr(if_instr), .if_pc(if_pc),
        .if_valid(if_valid), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    assign imem_data = (imem_addr < MEMSZ) ? mem[imem_addr[4:0]] : 32'h0;

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_instr = 0; m_ipc = 0; m_vld = 0; m_fault = 0;
    endtask

    task automatic model_edge();
        logic [31:0] w;
        w = mem[m_pc];
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (redirect && redirect_addr >= MEMSZ) begin
                m_fault = 1; m_vld = 0; m_mode = 2;
            end else if (redirect) begin
                m_pc = redirect_addr; m_vld = 0;
            end else if (!stall) begin
                m_instr = w; m_ipc = m_pc; m_vld = 1;
                if (w[31:26] == 6'd63) m_mode = 2;
                else m_pc = (m_pc + 1) % MEMSZ;
            end
        end else begin
            if (redirect && redirect_addr >= MEMSZ) begin
                m_fault = 1; m_vld = 0;
            end else if (redirect && !m_fault) begin
                m_pc = redirect_addr; m_vld = 0; m_mode = 1;
            end else if (!stall) begin
                m_vld = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fill_seq();
        for (int k = 0; k < MEMSZ; k++) mem[k] = {6'd1, 26'(k)};
    endtask

    task automatic test_reset();
        fill_seq();
        rst_n = 1'b0;
        model_reset();
        #3;
        n_cmp += 6;
        if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_valid); end
        if (if_pc !== 32'd0) begin n_fail++; $display("FAIL rst_pc: got %0d want 0", if_pc); end
        if (if_instr !== 32'd0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", if_instr); end
        if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", imem_addr); end
        if (halted !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got halted=%b fault=%b want 0/0", halted, fault); end
        if (imem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", imem_we); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (if_valid !== 1'b0) begin n_fail++; $display("FAIL start_bubble: got valid=%b want 0", if_valid); end
        step();
        n_cmp++;
        if (if_valid !== 1'b1 || if_pc !== 32'd0) begin n_fail++; $display("FAIL first_fetch: got valid=%b pc=%0d want 1/0", if_valid, if_pc); end
    endtask

    task automatic test_sequential();
        logic [31:0] prev;
        int wraps;
        wraps = 0;
        prev = if_pc;
        for (int i = 0; i < 40; i++) begin
            step();
            n_cmp += 3;
            if (if_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid: cycle %0d got %b want 1", i, if_valid); end
            if (if_pc !== m_ipc || if_pc !== (prev + 1) % MEMSZ) begin n_fail++; $display("FAIL seq_pc: cycle %0d got %0d want %0d", i, if_pc, m_ipc); end
            if (if_instr !== {6'd1, 26'(m_ipc)}) begin n_fail++; $display("FAIL seq_instr: got %h want %h", if_instr, {6'd1, 26'(m_ipc)}); end
            if (prev == 31 && if_pc == 0) wraps++;
            prev = if_pc;
        end
        n_cmp++;
        if (wraps < 1) begin n_fail++; $display("FAIL seq_wrap: got %0d wraps want >=1", wraps); end
    endtask

    task automatic test_stall();
        int b;
        do_reset();
        b = 0;
        while (!(if_valid && if_pc == 5) && b < 64) begin step(); b++; end
        n_cmp++;
        if (b >= 64) begin n_fail++; $display("FAIL stall_wait: got timeout want if_pc=5"); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp += 3;
            if (if_pc !== 32'd5 || if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold_pc: got %0d/%b want 5/1", if_pc, if_valid); end
            if (if_instr !== {6'd1, 26'd5}) begin n_fail++; $display("FAIL stall_hold_instr: got %h want %h", if_instr, {6'd1, 26'd5}); end
            if (imem_addr !== 32'd6) begin n_fail++; $display("FAIL stall_addr: got %0d want 6", imem_addr); end
        end
        stall = 1'b0;
        step();
        n_cmp++;
        if (if_pc !== 32'd6 || if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %0d/%b want 6/1", if_pc, if_valid); end
    endtask

    task automatic test_redirect();
        int b;
        b = 0;
        while (imem_addr != 7 && b < 64) begin step(); b++; end
        n_cmp++;
        if (b >= 64) begin n_fail++; $display("FAIL redir_wait: got timeout want imem_addr=7"); end
        redirect = 1'b1; redirect_addr = 32'd20; stall = 1'b1;
        step();
        redirect = 1'b0; stall = 1'b0;
        n_cmp += 2;
        if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble: got %b want 0", if_valid); end
        if (imem_addr !== 32'd20) begin n_fail++; $display("FAIL redir_addr: got %0d want 20", imem_addr); end
        step();
        n_cmp++;
        if (if_pc !== 32'd20 || if_valid !== 1'b1) begin n_fail++; $display("FAIL redir_target: got %0d/%b want 20/1", if_pc, if_valid); end
    endtask

    task automatic test_halt();
        int b;
        mem[10] = {6'b111111, 26'd10};
        do_reset();
        b = 0;
        while (!(if_valid && if_pc == 10) && b < 64) begin step(); b++; end
        n_cmp += 2;
        if (b >= 64) begin n_fail++; $display("FAIL halt_wait: got timeout want if_pc=10"); end
        if (halted !== 1'b1 || if_valid !== 1'b1) begin n_fail++; $display("FAIL halt_deliver: got halted=%b valid=%b want 1/1", halted, if_valid); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (if_valid !== 1'b0 || imem_addr !== 32'd10 || halted !== 1'b1) begin
                n_fail++; $display("FAIL halt_hold: got valid=%b addr=%0d halted=%b want 0/10/1", if_valid, imem_addr, halted);
            end
        end
        redirect = 1'b1; redirect_addr = 32'd3;
        step();
        redirect = 1'b0;
        n_cmp++;
        if (if_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 32'd3) begin
            n_fail++; $display("FAIL halt_squash: got valid=%b halted=%b addr=%0d want 0/0/3", if_valid, halted, imem_addr);
        end
        step();
        n_cmp++;
        if (if_pc !== 32'd3 || if_valid !== 1'b1 || if_instr !== {6'd1, 26'd3}) begin
            n_fail++; $display("FAIL halt_resume: got pc=%0d valid=%b want 3/1", if_pc, if_valid);
        end
        mem[10] = {6'd1, 26'd10};
    endtask

    task automatic test_fault();
        logic [31:0] held;
        step(); step();
        held = imem_addr;
        redirect = 1'b1; redirect_addr = 32'd32;
        step();
        n_cmp += 2;
        if (fault !== 1'b1 || halted !== 1'b1 || if_valid !== 1'b0) begin
            n_fail++; $display("FAIL fault_set: got fault=%b halted=%b valid=%b want 1/1/0", fault, halted, if_valid);
        end
        if (imem_addr !== held) begin n_fail++; $display("FAIL fault_pc_hold: got %0d want %0d", imem_addr, held); end
        redirect_addr = 32'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (fault !== 1'b1 || halted !== 1'b1 || imem_addr !== held) begin
                n_fail++; $display("FAIL fault_sticky: got fault=%b halted=%b addr=%0d want 1/1/%0d", fault, halted, imem_addr, held);
            end
        end
        redirect = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (fault !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL fault_clear: got fault=%b halted=%b want 0/0", fault, halted); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 6; i++) step();
        #2;
        rst_n = 1'b0; redirect = 1'b1; redirect_addr = 32'd17; stall = 1'b1;
        model_reset();
        #1;
        n_cmp += 2;
        if (if_valid !== 1'b0 || if_pc !== 32'd0 || if_instr !== 32'd0) begin
            n_fail++; $display("FAIL async_clear: got valid=%b pc=%0d instr=%h want 0/0/0", if_valid, if_pc, if_instr);
        end
        if (imem_addr !== 32'd0 || halted !== 1'b0) begin n_fail++; $display("FAIL async_addr: got %0d/%b want 0/0", imem_addr, halted); end
        step();
        n_cmp++;
        if (imem_addr !== 32'd0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL async_held: got %0d/%b want 0/0", imem_addr, if_valid); end
        @(negedge clk);
        rst_n = 1'b1; redirect = 1'b0; stall = 1'b0;
        step(); step();
        n_cmp++;
        if (if_pc !== 32'd0 || if_valid !== 1'b1) begin n_fail++; $display("FAIL async_resume: got %0d/%b want 0/1", if_pc, if_valid); end
    endtask

    task automatic test_random();
        for (int k = 0; k < MEMSZ; k++)
            mem[k] = {($urandom_range(0, 15) == 0) ? 6'b111111 : 6'($urandom_range(0, 62)), 26'($urandom)};
        do_reset();
        for (int i = 0; i < 600; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 7) == 0);
            redirect_addr = (($urandom_range(0, 15) == 0) ? 32'($urandom_range(32, 40)) : 32'($urandom_range(0, 31)));
            if (m_fault && $urandom_range(0, 5) == 0) do_reset();
            step();
            n_cmp += 5;
            if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr: cycle %0d got %0d want %0d", i, imem_addr, m_pc); end
            if (if_valid !== m_vld) begin n_fail++; $display("FAIL rnd_valid: cycle %0d got %b want %b", i, if_valid, m_vld); end
            if (if_pc !== m_ipc || if_instr !== m_instr) begin n_fail++; $display("FAIL rnd_ifid: cycle %0d got %0d/%h want %0d/%h", i, if_pc, if_instr, m_ipc, m_instr); end
            if (halted !== (m_mode == 2)) begin n_fail++; $display("FAIL rnd_halted: cycle %0d got %b want %b", i, halted, m_mode == 2); end
            if (fault !== m_fault) begin n_fail++; $display("FAIL rnd_fault: cycle %0d got %b want %b", i, fault, m_fault); end
        end
        stall = 1'b0; redirect = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_halt();
        test_fault();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
